onoff_spike_encoder: RTL

Upstream stage of the on/off center-surround filter. It accepts one 3x3 pixel patch of intensities over a valid/ready handshake and converts each pixel to a race-logic step signal: brighter pixels step high earlier. It then replays all nine steps over one gamma window and pulses the filter reset before each window.
Outputs drive filter_center_in, filter_edge_in[0:7] and rst of the downstream filter directly.

---
 rtl/onoff_spike_encoder_if.sv | 31 +++
 rtl/onoff_spike_encoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/onoff_spike_encoder_if.sv
// -----------------------------------------------------------------------------
// onoff_spike_encoder_if
//
// Patch handshake between a pixel source (master) and the on/off spike
// encoder (slave).
//
// Signals:
//   in_valid   master -> slave   patch valid
//   in_ready   slave  -> master  encoder can accept a patch
//   pix_in     master -> slave   9 pixels; slice j = pix_in[j*PIX_W +: PIX_W],
//                                j=0..7 edges, j=8 center
//   thresh_in  master -> slave   silence threshold (only with PIXEL_THRESHOLD_EN)
//
// Build option: PIXEL_THRESHOLD_EN adds thresh_in.
// -----------------------------------------------------------------------------
interface onoff_spike_encoder_if #(
    parameter int PIX_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [9*PIX_W-1:0]   pix_in;
`ifdef PIXEL_THRESHOLD_EN
    logic [PIX_W-1:0]     thresh_in;

    modport master (output in_valid, output pix_in, output thresh_in, input in_ready);
    modport slave  (input in_valid, input pix_in, input thresh_in, output in_ready);
`else
    modport master (output in_valid, output pix_in, input in_ready);
    modport slave  (input in_valid, input pix_in, output in_ready);
`endif
endinterface

// File: rtl/onoff_spike_encoder.sv
// -----------------------------------------------------------------------------
// onoff_spike_encoder
//
// Accepts one 3x3 intensity patch, converts each pixel into a race-logic step
// time (brighter = earlier), then replays all nine steps over one gamma window
// preceded by a one-cycle reset pulse to the downstream on/off filter.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-low reset
//   bus               patch handshake (onoff_spike_encoder_if.slave)
//   filter_rst        one-cycle active-high reset to the downstream filter
//   filter_center_in  center step signal (pixel 8)
//   filter_edge_in    edge step signals, bit j from pixel j
//   window_active     high while the window is being replayed
//   window_done       one-cycle pulse after the last window cycle
//
// Build option: PIXEL_THRESHOLD_EN -- pixels below bus.thresh_in (sampled at
// the handshake) stay silent for the whole window.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a patch, in_ready=1
// RST   | one cycle, pulse filter_rst, all steps low
// RUN   | replay window, t counts 0..GAMMA_LEN-1, steps = (t >= time_j)
// DONE  | one cycle, pulse window_done, all steps low
// -----------------------------------------------------------------------------
module onoff_spike_encoder #(
    parameter int PIX_W    = 8,
    parameter int TIME_W   = 6,
    parameter int LEAVEWAY = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    onoff_spike_encoder_if.slave bus,
    output logic                 filter_rst,
    output logic                 filter_center_in,
    output logic [0:7]           filter_edge_in,
    output logic                 window_active,
    output logic                 window_done
);

    localparam int               SHIFT     = PIX_W - TIME_W;
    localparam int               GAMMA_LEN = 2**TIME_W + LEAVEWAY;
    localparam logic [TIME_W:0]  T_LAST    = (TIME_W+1)'(GAMMA_LEN - 1);

    typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [TIME_W:0]          t_q, t_d;
    logic [8:0][TIME_W-1:0]   time_q, time_d;
    logic [8:0]               silent_q, silent_d;
    logic [8:0]               step_q, step_d;
    logic                     filter_rst_q, filter_rst_d;
    logic                     active_q, active_d;
    logic                     done_q, done_d;
    logic [PIX_W-1:0]         inv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            t_q          <= '0;
            time_q       <= '0;
            silent_q     <= '0;
            step_q       <= '0;
            filter_rst_q <= 1'b0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            time_q       <= time_d;
            silent_q     <= silent_d;
            step_q       <= step_d;
            filter_rst_q <= filter_rst_d;
            active_q     <= active_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        time_d   = time_q;
        silent_d = silent_q;
        step_d   = '0;
        inv      = '0;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    for (int j = 0; j < 9; j++) begin
                        // (2^PIX_W-1 - pix) is the bitwise inverse for unsigned pix
                        inv       = ~bus.pix_in[j*PIX_W +: PIX_W];
                        time_d[j] = TIME_W'(inv >> SHIFT);
`ifdef PIXEL_THRESHOLD_EN
                        silent_d[j] = (bus.pix_in[j*PIX_W +: PIX_W] < bus.thresh_in);
`else
                        silent_d[j] = 1'b0;
`endif
                    end
                    state_d = RST;
                end
            end
            RST: begin
                t_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                if (t_q == T_LAST) begin
                    state_d = DONE;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            DONE: begin
                t_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: compute them from the values of the coming cycle.
        if (state_d == RUN) begin
            for (int j = 0; j < 9; j++) begin
                step_d[j] = ({1'b0, time_d[j]} <= t_d) && !silent_d[j];
            end
        end
        filter_rst_d = (state_d == RST);
        active_d     = (state_d == RUN);
        done_d       = (state_d == DONE);
    end

    assign bus.in_ready     = (state_q == IDLE);
    assign filter_rst       = filter_rst_q;
    assign filter_center_in = step_q[8];
    assign window_active    = active_q;
    assign window_done      = done_q;

    for (genvar j = 0; j < 8; j++) begin : g_edge
        assign filter_edge_in[j] = step_q[j];
    end

endmodule
